// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares the system memory bus (16-bit address, 8-bit data) between the CPU
// core and one DMA requester. The CPU owns the bus by default. The DMA side
// preempts it at cycle boundaries. Every change of owner passes through one
// dead turnaround cycle, during which no write strobe is issued.
//
// Optional feature (macro ARB_FAIRNESS_EN): a burst counter caps a DMA tenure
// at DMA_BURST_MAX transfers whenever the CPU is waiting. The CPU then gets a
// slot before the DMA side can take the bus back.
//
// Ports:
//   clock, reset                      clock; asynchronous active-high reset
//   cpu_req/we/address/data_out       CPU transfer request
//   cpu_stall                         CPU must hold its request
//   dma_req/we/address/data_out       DMA transfer request (held for a burst)
//   dma_grant, dma_ack                DMA owns the bus / DMA transfer done
//   dataInBus                         memory read data (combinational memory)
//   cpu_data_in, dma_data_in          read data to each requester
//   addressBus, dataOutBus, writeEnBus  shared memory bus
module mem_bus_arbiter #(
    parameter int DMA_BURST_MAX = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_data_out,
    output logic        dma_grant,
    output logic        dma_ack,
    input  logic [7:0]  dataInBus,
    output logic [7:0]  cpu_data_in,
    output logic [7:0]  dma_data_in,
    output logic [15:0] addressBus,
    output logic [7:0]  dataOutBus,
    output logic        writeEnBus
);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        TURN_D  = 2'd1,
        DMA_OWN = 2'd2,
        TURN_C  = 2'd3
    } state_t;

    state_t state;

    // Reject a burst cap the 8-bit counter cannot reach.
    if (DMA_BURST_MAX < 1 || DMA_BURST_MAX > 255) begin : g_bad_burst_max
        $error("mem_bus_arbiter: DMA_BURST_MAX must be in 1..255");
    end

    // Bus mux and handshake outputs, all decoded from the state register.
    always_comb begin
        addressBus = cpu_address;
        dataOutBus = cpu_data_out;
        writeEnBus = 1'b0;
        case (state)
            CPU_OWN: writeEnBus = cpu_req & cpu_we;
            DMA_OWN: begin
                addressBus = dma_address;
                dataOutBus = dma_data_out;
                writeEnBus = dma_req & dma_we;
            end
            default: writeEnBus = 1'b0;
        endcase
    end

    assign cpu_data_in = dataInBus;
    assign dma_data_in = dataInBus;
    assign dma_grant   = (state == DMA_OWN);
    assign dma_ack     = dma_grant & dma_req;
    assign cpu_stall   = cpu_req & (state != CPU_OWN);

    logic dma_take;   // CPU_OWN may hand the bus to DMA at this edge
    logic cap_hit;    // DMA tenure must end because the CPU is being starved

`ifdef ARB_FAIRNESS_EN
    logic [7:0] burst_cnt;
    logic       cpu_owed;
    logic [8:0] cnt_inc;

    // Compare on 9 bits so a saturated counter never aliases onto the cap.
    assign cnt_inc  = {1'b0, burst_cnt} + 9'd1;
    assign cap_hit  = dma_ack & cpu_req & (cnt_inc == 9'(DMA_BURST_MAX));
    // A CPU that was forced to wait keeps the bus for its owed slot.
    assign dma_take = dma_req & ~(cpu_owed & cpu_req);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= 8'd0;
            cpu_owed  <= 1'b0;
        end else begin
            case (state)
                CPU_OWN: cpu_owed <= 1'b0;
                TURN_D:  burst_cnt <= 8'd0;
                DMA_OWN: begin
                    if (dma_ack && burst_cnt != 8'hFF)
                        burst_cnt <= burst_cnt + 8'd1;
                    if (cap_hit)
                        cpu_owed <= 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    assign cap_hit  = 1'b0;
    assign dma_take = dma_req;
`endif

    // Owner FSM. Every change of owner passes through a turnaround state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CPU_OWN;
        end else begin
            case (state)
                CPU_OWN: if (dma_take) state <= TURN_D;
                TURN_D:  state <= DMA_OWN;
                DMA_OWN: if (!dma_req || cap_hit) state <= TURN_C;
                TURN_C:  state <= CPU_OWN;
                default: state <= CPU_OWN;
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single system memory bus (16-bit address, 8-bit data) between the CPU6 core and one DMA requester, such as a disk or console controller. The CPU is the default owner. The DMA requester preempts it at cycle boundaries, and one dead turnaround cycle separates every change of owner. An optional burst cap forces the DMA side to yield so the CPU cannot be starved.

## Interface
- DMA_BURST_MAX, 16: DMA transfers allowed per tenure before a forced yield to a pending CPU request. Range 1..255. Used only with the fairness feature.

- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_req  in  1  CPU wants a bus transfer this cycle
- cpu_we  in  1  CPU transfer is a write
- cpu_address  in  16  CPU address
- cpu_data_out  in  8  CPU write data
- cpu_stall  out  1  CPU must hold its request and freeze its sequencer
- dma_req  in  1  DMA wants the bus; hold high for the whole burst
- dma_we  in  1  DMA transfer is a write
- dma_address  in  16  DMA address
- dma_data_out  in  8  DMA write data
- dma_grant  out  1  DMA owns the bus
- dma_ack  out  1  DMA transfer completes this cycle
- dataInBus  in  8  memory read data (combinational memory)
- cpu_data_in  out  8  read data to CPU
- dma_data_in  out  8  read data to DMA
- addressBus  out  16  memory address
- dataOutBus  out  8  memory write data
- writeEnBus  out  1  memory write strobe

## Operation
- Registered state:
  - owner FSM with states CPU_OWN, TURN_D, DMA_OWN, TURN_C;
  - 8-bit burst counter;
  - cpu_owed flag.
- Bus mux, combinational from the FSM state:
  - DMA_OWN drives the dma_* inputs onto the bus.
  - CPU_OWN drives the cpu_* inputs onto the bus.
  - TURN_D and TURN_C drive cpu_address and cpu_data_out with writeEnBus=0.
- Request gating:
  - In CPU_OWN, writeEnBus = cpu_req & cpu_we.
  - In DMA_OWN, writeEnBus = dma_req & dma_we.
- Read data: cpu_data_in and dma_data_in both equal dataInBus at all times.
- cpu_stall = cpu_req & (state != CPU_OWN).
- dma_grant = (state == DMA_OWN).
- dma_ack = dma_grant & dma_req.
- Transitions:
  - CPU_OWN→TURN_D when dma_req & !(cpu_owed & cpu_req). A CPU transfer in the current cycle still completes.
  - CPU_OWN clears cpu_owed on any edge where cpu_req=1 or cpu_req=0 while it is owner, i.e. after one CPU slot.
  - TURN_D→DMA_OWN unconditionally. TURN_D clears the counter.
  - DMA_OWN: each dma_ack increments the counter, saturating at 255.
  - DMA_OWN→TURN_C when dma_req=0.
  - DMA_OWN→TURN_C on the fairness cap (see Configuration).
  - TURN_C→CPU_OWN unconditionally.
- dma_req dropping in TURN_D: DMA_OWN is entered anyway. No ack occurs and the FSM goes to TURN_C next.
- cpu_req and dma_req rising in the same cycle while in CPU_OWN: the CPU transfer completes and DMA is granted afterwards.

## Timing
- Reset values:
  - state CPU_OWN, counter 0, cpu_owed 0;
  - dma_grant 0, dma_ack 0;
  - writeEnBus = cpu_req & cpu_we;
  - cpu_stall 0.
- Reset asserted mid-burst returns ownership to the CPU immediately, with no turnaround.
- Grant latency: dma_req sampled high at edge E gives TURN_D after E and DMA_OWN after E+1. The first dma_ack is in the cycle after E+1.
- Release latency: dma_req low at edge E gives TURN_C after E and CPU_OWN after E+1. CPU stall is 2 cycles minimum after a burst ends.
- Back-to-back DMA transfers: one per clock while dma_req stays high.

## Configuration
- ARB_FAIRNESS_EN defined:
  - In DMA_OWN, when dma_ack occurs with counter+1 == DMA_BURST_MAX and cpu_req=1, the FSM goes to TURN_C and sets cpu_owed.
  - The DMA side re-acquires the bus only after the CPU has had one CPU_OWN cycle.
- ARB_FAIRNESS_EN undefined:
  - The counter and cpu_owed are not built.
  - DMA holds the bus until dma_req drops.
  - CPU_OWN→TURN_D on dma_req alone.

## Test plan
- Reset with cpu_req=1, cpu_we=1, cpu_address=16'h1234 → addressBus=1234, writeEnBus=1, cpu_stall=0, dma_grant=0.
- dma_req rises at edge 10 with dma_address=16'h8000 → TURN_D in cycle 11 with writeEnBus=0. dma_grant=1 and dma_ack=1 from cycle 12, with addressBus=8000.
- DMA burst of 3 writes, then dma_req drops → 3 dma_ack pulses, then TURN_C, then CPU_OWN. cpu_stall=1 during the burst and the turnaround.
- ARB_FAIRNESS_EN, DMA_BURST_MAX=4, dma_req and cpu_req held high → 4 acks, TURN_C, one CPU cycle with cpu_stall=0, TURN_D, and DMA again. This repeats periodically.
- Reset asserted during the 2nd DMA_OWN cycle → dma_grant=0 and addressBus=cpu_address in the same cycle. After release the FSM is in CPU_OWN with counter 0.
